// File: rtl/cur_mb_load_ctrl_pkg.sv
// Shared constants and types for the current-LCU original-pixel load path.
package cur_mb_load_ctrl_pkg;

  localparam int PIXEL_WIDTH = 8;
  localparam int LUMA_ROWS   = 128;
  localparam int CHROMA_ROWS = 64;
  localparam int NUM_GRP     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_e;

  // Unrotated bank order: bank0..3 take groups G3, G1, G2, G0.
  function automatic logic [1:0] base_grp(input logic [1:0] bank);
    case (bank)
      2'd0:    return 2'd3;
      2'd1:    return 2'd1;
      2'd2:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/cur_mb_rot4.sv
// Combinational 4-group rotator: bank b takes base group (b - phase) mod 4.
module cur_mb_rot4
  import cur_mb_load_ctrl_pkg::*;
#(
  parameter int GRP_W = 64
) (
  input  logic [NUM_GRP*GRP_W-1:0] data,
  input  logic [1:0]               phase,
  output logic [NUM_GRP*GRP_W-1:0] rot
);

  logic [NUM_GRP-1:0][GRP_W-1:0] grp;
  // Index 0 is the MSB slice so the output reads {bank0, bank1, bank2, bank3}.
  logic [0:NUM_GRP-1][GRP_W-1:0] bank;

  assign grp = data;

  for (genvar b = 0; b < NUM_GRP; b++) begin : g_bank
    assign bank[b] = grp[base_grp(2'(b) - phase)];
  end

  assign rot = bank;

endmodule

// File: rtl/cur_mb_load_ctrl.sv
// Load sequencer for the current-LCU pixel buffer: streams 192 rows in,
// rotates each row for the four bank RAMs and yields the port to reads.
module cur_mb_load_ctrl
  import cur_mb_load_ctrl_pkg::*;
#(
  parameter int PIXEL_WIDTH = cur_mb_load_ctrl_pkg::PIXEL_WIDTH,
  parameter int LUMA_ROWS   = cur_mb_load_ctrl_pkg::LUMA_ROWS,
  parameter int CHROMA_ROWS = cur_mb_load_ctrl_pkg::CHROMA_ROWS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [PIXEL_WIDTH*32-1:0] in_data_i,
  input  logic                      cur_ren_i,
  output logic                      wen_o,
  output logic [7:0]                addr_o,
  output logic [PIXEL_WIDTH*32-1:0] wdata_o,
  output logic                      chroma_o
);

  localparam logic [7:0] LAST_ROW   = 8'(LUMA_ROWS + CHROMA_ROWS - 1);
  localparam logic [7:0] CHROMA_ROW = 8'(LUMA_ROWS);

  ld_state_e  state;
  logic [7:0] row;
  logic       accept;

  // Single-port banks: a read request always takes the cycle.
  assign in_ready_o = (state == ST_LOAD) & ~cur_ren_i;
  assign accept     = in_valid_i & in_ready_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      row   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start_i) begin
          state <= ST_LOAD;
          row   <= '0;
        end
        ST_LOAD: if (accept) begin
          row <= row + 8'd1;
          if (row == LAST_ROW) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy_o   = (state != ST_IDLE);
  assign done_o   = (state == ST_DONE);
  assign chroma_o = (state == ST_LOAD) & (row >= CHROMA_ROW);
  assign wen_o    = accept;
  assign addr_o   = row;

  cur_mb_rot4 #(.GRP_W(PIXEL_WIDTH*8)) u_rot (
    .data  (in_data_i),
    .phase (row[1:0]),
    .rot   (wdata_o)
  );

endmodule

// File: tb/tb_cur_mb_load_ctrl.sv
// Directed bench for cur_mb_load_ctrl: per-cycle comparison against a
// row-level behavioural model plus literal checks of rotation and timing.
module tb_cur_mb_load_ctrl;

  localparam int ROWS = 192;
  localparam logic [63:0] C0 = 64'h0000000000000000;
  localparam logic [63:0] C1 = 64'h1111111111111111;
  localparam logic [63:0] C2 = 64'h2222222222222222;
  localparam logic [63:0] C3 = 64'h3333333333333333;

  logic         clk = 0, rst = 1, start = 0, vld = 0, ren = 0;
  logic [255:0] data = '0;
  logic         busy_o, done_o, in_ready_o, wen_o, chroma_o;
  logic [7:0]   addr_o;
  logic [255:0] wdata_o;

  cur_mb_load_ctrl dut (
    .clk(clk), .rst(rst), .start_i(start), .busy_o(busy_o), .done_o(done_o),
    .in_valid_i(vld), .in_ready_o(in_ready_o), .in_data_i(data),
    .cur_ren_i(ren), .wen_o(wen_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .chroma_o(chroma_o)
  );

  always #5 clk = ~clk;

  int vectors = 0, errs = 0;
  bit armed = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Bank b of phase p holds group perm[p][b], as tabulated for the four phases.
  int perm [4][4] = '{'{3,1,2,0}, '{0,3,1,2}, '{2,0,3,1}, '{1,2,0,3}};

  function automatic logic [255:0] rot_m(input logic [255:0] d, input int p);
    logic [255:0] r;
    for (int b = 0; b < 4; b++) r[255-64*b -: 64] = d[64*perm[p][b] +: 64];
    return r;
  endfunction

  // Model: loading flag, next row to write, done-cycle flag.
  bit m_load = 0, m_done = 0;
  int m_row = 0;

  always @(negedge clk) begin
    bit ew;
    ew = m_load && !ren && vld;
    if (armed) begin
      chk("in_ready", in_ready_o, m_load && !ren);
      chk("wen", wen_o, ew);
      chk("busy", busy_o, m_load || m_done);
      chk("done", done_o, m_done);
      chk("chroma", chroma_o, m_load && m_row >= 128);
      if (ew) begin
        chk("addr", addr_o, m_row);
        chk("wdata", wdata_o, rot_m(data, m_row % 4));
      end
    end
    if (rst) begin
      m_load = 0; m_done = 0; m_row = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_load) begin
      if (ew) begin
        m_row++;
        if (m_row == ROWS) begin m_load = 0; m_done = 1; end
      end
    end else if (start) begin
      m_load = 1; m_row = 0;
    end
  end

  // One LCU load. ren_mode 1: read request on every odd cycle after start.
  task automatic run_load(input int ren_mode, input bit gaps, input bit rotpat,
                          input bit start_poke, input int rst_row,
                          output int done_cyc, output int last_acc);
    int idx = 0, cyc = 0, gap = 0, ndone = 0, bad = 0;
    int wr [ROWS];
    bit acc;
    logic [7:0] b;
    logic [255:0] lit [4];
    lit[0] = {C3, C1, C2, C0};
    lit[1] = {C0, C3, C1, C2};
    lit[2] = {C2, C0, C3, C1};
    lit[3] = {C1, C2, C0, C3};
    done_cyc = -1; last_acc = -1;
    foreach (wr[i]) wr[i] = 0;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    while (cyc < 1000) begin
      cyc++;
      b     = idx[7:0];
      ren   = (ren_mode == 1) && (cyc % 2 == 1);
      vld   = (gap == 0) && (idx < ROWS);
      data  = rotpat ? {C3, C2, C1, C0} : {32{b}};
      start = start_poke && (idx == 10 || idx == 191 || (idx == ROWS && cyc == last_acc + 1));
      rst   = (rst_row >= 0) && (idx == rst_row);
      @(negedge clk);
      if (rst) begin
        @(posedge clk); #1 rst = 0; start = 0; vld = 1; ren = 0;
        @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_wen", wen_o, 0);
        vld = 0;
        return;
      end
      acc = vld && in_ready_o;
      if (acc) begin
        if (addr_o < ROWS) wr[addr_o]++;
        if (rotpat && (idx < 4 || (idx >= 128 && idx < 132)))
          chk("rot_lit", wdata_o, lit[idx % 4]);
        last_acc = cyc;
        idx++;
        if (gaps) gap = $urandom_range(1, 5);
      end else if (gap > 0) gap--;
      if (done_o) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      @(posedge clk); #1;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    start = 0; vld = 0; ren = 0;
    chk("done_count", ndone, 1);
    foreach (wr[i]) if (wr[i] != 1) bad++;
    chk("rows_once", bad, 0);
  endtask

  initial begin
    int dc, la;
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    armed = 1;
    @(negedge clk);
    chk("reset_addr", addr_o, 0);
    chk("reset_busy", busy_o, 0);

    run_load(0, 0, 0, 0, -1, dc, la);
    chk("t1_done_cyc", dc, 193);
    chk("t1_last_acc", la, 192);

    run_load(0, 0, 1, 0, -1, dc, la);
    chk("t2_done_cyc", dc, 193);

    run_load(1, 0, 0, 0, -1, dc, la);
    chk("t3_last_acc", la, 384);

    run_load(0, 1, 0, 0, -1, dc, la);

    run_load(0, 0, 0, 1, -1, dc, la);
    chk("t5_done_cyc", dc, 193);

    run_load(0, 0, 0, 0, 77, dc, la);
    run_load(0, 0, 0, 0, -1, dc, la);
    chk("t7_done_cyc", dc, 193);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
